// File: rtl/nand_op_sequencer.sv
// Operation sequencer for the NAND flash interface: runs one READ/PROGRAM/ERASE/STATUS at a time.
// Build option AUTO_STATUS_EN: PROGRAM/ERASE append a 70h status read and fail on statusByte[0].
module nand_op_sequencer #(
  parameter logic [15:0] TIMEOUT  = 16'd4096,
  parameter int unsigned RB_GUARD = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        opValid,
  input  logic [1:0]  opCode,
  input  logic [31:0] opAddress,
  output logic        opReady,
  output logic        busy,
  output logic        opDone,
  output logic        opError,
  input  logic        feedbackCommand,
  input  logic        feedbackALC,
  input  logic        feedbackWR,
  input  logic        feedbackRO,
  input  logic        nandRB,
  input  logic [7:0]  statusByte,
  output logic        startCommand,
  output logic        startALC,
  output logic        startWR,
  output logic        startRO,
  output logic [7:0]  commandByte,
  output logic [31:0] toAddressLine,
  output logic [2:0]  addrCycles,
  output logic [1:0]  MUXselectline
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CMD1      = 4'd1;
  localparam logic [3:0] ST_CMD1_W    = 4'd2;
  localparam logic [3:0] ST_ADDR      = 4'd3;
  localparam logic [3:0] ST_ADDR_W    = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_W   = 4'd6;
  localparam logic [3:0] ST_CMD2      = 4'd7;
  localparam logic [3:0] ST_CMD2_W    = 4'd8;
  localparam logic [3:0] ST_BUSY_WAIT = 4'd9;
  localparam logic [3:0] ST_RDATA     = 4'd10;
  localparam logic [3:0] ST_RDATA_W   = 4'd11;
  localparam logic [3:0] ST_DONE      = 4'd12;
  localparam logic [3:0] ST_ERROR     = 4'd13;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_PROGRAM = 2'b01;
  localparam logic [1:0] OP_ERASE   = 2'b10;
  localparam logic [1:0] OP_STATUS  = 2'b11;

  localparam logic [1:0] MUX_CMD   = 2'b00;
  localparam logic [1:0] MUX_ADDR  = 2'b01;
  localparam logic [1:0] MUX_WDATA = 2'b10;
  localparam logic [1:0] MUX_RDATA = 2'b11;

  localparam logic [15:0] RB_GUARD_W = 16'(RB_GUARD);

  logic [3:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  addr_cycles_q, addr_cycles_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic [1:0]  mux_q, mux_d;
  logic [15:0] tmo_q, tmo_d;
  logic        status_phase_q, status_phase_d;
  logic        start_cmd_q, start_cmd_d;
  logic        start_alc_q, start_alc_d;
  logic        start_wr_q, start_wr_d;
  logic        start_ro_q, start_ro_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        timed_out, rb_ready, waiting;

`ifndef AUTO_STATUS_EN
  logic status_unused;
  assign status_unused = ^statusByte;
`endif

  assign timed_out = (tmo_q == TIMEOUT - 16'd1);
  assign rb_ready  = (tmo_q >= RB_GUARD_W) && nandRB;
  assign waiting   = (state_q == ST_CMD1_W) || (state_q == ST_ADDR_W) || (state_q == ST_WDATA_W) ||
                     (state_q == ST_CMD2_W) || (state_q == ST_BUSY_WAIT) || (state_q == ST_RDATA_W);

  // Next-state logic; an exit condition always takes priority over the timeout.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    addr_cycles_d  = addr_cycles_q;
    status_phase_d = status_phase_q;
    case (state_q)
      ST_IDLE: begin
        status_phase_d = 1'b0;
        if (opValid) begin
          state_d       = ST_CMD1;
          op_d          = opCode;
          addr_d        = opAddress;
          addr_cycles_d = (opCode == OP_ERASE)  ? 3'd3 :
                          (opCode == OP_STATUS) ? 3'd0 : 3'd5;
        end
      end
      ST_CMD1:    state_d = ST_CMD1_W;
      ST_CMD1_W:
        if (feedbackCommand)
          state_d = ((op_q == OP_STATUS) || status_phase_q) ? ST_RDATA : ST_ADDR;
        else if (timed_out) state_d = ST_ERROR;
      ST_ADDR:    state_d = ST_ADDR_W;
      ST_ADDR_W:
        if (feedbackALC) state_d = (op_q == OP_PROGRAM) ? ST_WDATA : ST_CMD2;
        else if (timed_out) state_d = ST_ERROR;
      ST_WDATA:   state_d = ST_WDATA_W;
      ST_WDATA_W:
        if (feedbackWR) state_d = ST_CMD2;
        else if (timed_out) state_d = ST_ERROR;
      ST_CMD2:    state_d = ST_CMD2_W;
      ST_CMD2_W:
        if (feedbackCommand) state_d = ST_BUSY_WAIT;
        else if (timed_out) state_d = ST_ERROR;
      ST_BUSY_WAIT:
        if (rb_ready) begin
          if (op_q == OP_READ) state_d = ST_RDATA;
          else begin
`ifdef AUTO_STATUS_EN
            state_d        = ST_CMD1;
            status_phase_d = 1'b1;
`else
            state_d = ST_DONE;
`endif
          end
        end else if (timed_out) state_d = ST_ERROR;
      ST_RDATA:   state_d = ST_RDATA_W;
      ST_RDATA_W:
        if (feedbackRO) begin
`ifdef AUTO_STATUS_EN
          state_d = (status_phase_q && statusByte[0]) ? ST_ERROR : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end else if (timed_out) state_d = ST_ERROR;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    tmo_d       = (waiting && (state_d == state_q)) ? tmo_q + 16'd1 : 16'd0;
    start_cmd_d = (state_d == ST_CMD1) || (state_d == ST_CMD2);
    start_alc_d = (state_d == ST_ADDR);
    start_wr_d  = (state_d == ST_WDATA);
    start_ro_d  = (state_d == ST_RDATA);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
    mux_d       = mux_q;
    cmd_byte_d  = cmd_byte_q;
    case (state_d)
      ST_IDLE, ST_CMD1, ST_CMD2: mux_d = MUX_CMD;
      ST_ADDR:                   mux_d = MUX_ADDR;
      ST_WDATA:                  mux_d = MUX_WDATA;
      ST_RDATA:                  mux_d = MUX_RDATA;
      default:                   mux_d = mux_q;
    endcase
    if (state_d == ST_CMD1) begin
      if (status_phase_d) cmd_byte_d = 8'h70;
      else begin
        case (op_d)
          OP_READ:    cmd_byte_d = 8'h00;
          OP_PROGRAM: cmd_byte_d = 8'h80;
          OP_ERASE:   cmd_byte_d = 8'h60;
          default:    cmd_byte_d = 8'h70;
        endcase
      end
    end else if (state_d == ST_CMD2) begin
      case (op_d)
        OP_READ:    cmd_byte_d = 8'h30;
        OP_PROGRAM: cmd_byte_d = 8'h10;
        default:    cmd_byte_d = 8'hD0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_READ;
      addr_q         <= '0;
      addr_cycles_q  <= '0;
      cmd_byte_q     <= '0;
      mux_q          <= MUX_CMD;
      tmo_q          <= '0;
      status_phase_q <= 1'b0;
      start_cmd_q    <= 1'b0;
      start_alc_q    <= 1'b0;
      start_wr_q     <= 1'b0;
      start_ro_q     <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      addr_cycles_q  <= addr_cycles_d;
      cmd_byte_q     <= cmd_byte_d;
      mux_q          <= mux_d;
      tmo_q          <= tmo_d;
      status_phase_q <= status_phase_d;
      start_cmd_q    <= start_cmd_d;
      start_alc_q    <= start_alc_d;
      start_wr_q     <= start_wr_d;
      start_ro_q     <= start_ro_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign opReady       = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign opDone        = done_q;
  assign opError       = error_q;
  assign startCommand  = start_cmd_q;
  assign startALC      = start_alc_q;
  assign startWR       = start_wr_q;
  assign startRO       = start_ro_q;
  assign commandByte   = cmd_byte_q;
  assign toAddressLine = addr_q;
  assign addrCycles    = addr_cycles_q;
  assign MUXselectline = mux_q;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Scoreboard bench for nand_op_sequencer: expected engine pulses and done/error are queued per
// operation; a monitor pops one entry per observed pulse. Engines are modelled by a responder.
module tb_nand_op_sequencer;

  localparam int TIMEOUT_CYC  = 4096;
  localparam int RB_GUARD_CYC = 4;

  typedef enum logic [2:0] {EV_CMD, EV_ALC, EV_WR, EV_RO, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  cmd;
    logic [1:0]  mux;
    logic [2:0]  acyc;
    logic [31:0] addr;
  } exp_ev_t;

  logic        CLK = 1'b0;
  logic        reset, opValid, opReady, busy, opDone, opError;
  logic [1:0]  opCode;
  logic [31:0] opAddress;
  logic        feedbackCommand, feedbackALC, feedbackWR, feedbackRO, nandRB;
  logic [7:0]  statusByte;
  logic        startCommand, startALC, startWR, startRO;
  logic [7:0]  commandByte;
  logic [31:0] toAddressLine;
  logic [2:0]  addrCycles;
  logic [1:0]  MUXselectline;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  exp_ev_t     exp_q[$];
  int          rb_low = 0;
  bit          drop_alc = 1'b0;
  int          alc_cyc = 0, done_cyc = 0, err_cyc = 0, st70_cyc = 0, fb_cmd2_cyc = 0;

  nand_op_sequencer dut (
    .CLK(CLK), .reset(reset), .opValid(opValid), .opCode(opCode), .opAddress(opAddress),
    .opReady(opReady), .busy(busy), .opDone(opDone), .opError(opError),
    .feedbackCommand(feedbackCommand), .feedbackALC(feedbackALC), .feedbackWR(feedbackWR),
    .feedbackRO(feedbackRO), .nandRB(nandRB), .statusByte(statusByte),
    .startCommand(startCommand), .startALC(startALC), .startWR(startWR), .startRO(startRO),
    .commandByte(commandByte), .toAddressLine(toAddressLine), .addrCycles(addrCycles),
    .MUXselectline(MUXselectline)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [7:0] c, input logic [1:0] m,
                      input logic [2:0] a, input logic [31:0] ad);
    exp_ev_t e;
    e.kind = k; e.cmd = c; e.mux = m; e.acyc = a; e.addr = ad;
    exp_q.push_back(e);
  endtask

  // PROGRAM/ERASE ending: optional status read, then done or error.
  task automatic push_pe_tail();
`ifdef AUTO_STATUS_EN
    push(EV_CMD, 8'h70, 2'b00, 3'd0, 32'h0);
    push(EV_RO, 8'h00, 2'b11, 3'd0, 32'h0);
    push(statusByte[0] ? EV_ERR : EV_DONE, 8'h00, 2'b00, 3'd0, 32'h0);
`else
    push(EV_DONE, 8'h00, 2'b00, 3'd0, 32'h0);
`endif
  endtask

  task automatic handle(input ev_kind_t k);
    exp_ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", k, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      case (k)
        EV_CMD: begin
          check("command_byte", 32'(commandByte), 32'(e.cmd));
          check("mux_cmd", 32'(MUXselectline), 32'(e.mux));
          if (commandByte == 8'h70) st70_cyc = cyc;
        end
        EV_ALC: begin
          check("mux_addr", 32'(MUXselectline), 32'(e.mux));
          check("addr_cycles", 32'(addrCycles), 32'(e.acyc));
          check("to_address_line", toAddressLine, e.addr);
          alc_cyc = cyc;
        end
        EV_WR, EV_RO: check("mux_data", 32'(MUXselectline), 32'(e.mux));
        EV_DONE: done_cyc = cyc;
        default: err_cyc = cyc;
      endcase
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (!reset) begin
        if (startCommand) handle(EV_CMD);
        if (startALC)     handle(EV_ALC);
        if (startWR)      handle(EV_WR);
        if (startRO)      handle(EV_RO);
        if (opDone)       handle(EV_DONE);
        if (opError)      handle(EV_ERR);
      end
    end
  end

  function automatic bit is_cmd2(input logic [7:0] b);
    return (b == 8'h30) || (b == 8'h10) || (b == 8'hD0);
  endfunction

  // Engine model: each feedback is a 1-cycle pulse 3 cycles after its start pulse.
  initial begin : responder
    int c_cmd, c_alc, c_wr, c_ro, c_rb;
    logic [7:0] pend_byte;
    c_cmd = 0; c_alc = 0; c_wr = 0; c_ro = 0; c_rb = 0; pend_byte = 8'h00;
    forever begin
      @(negedge CLK);
      feedbackCommand = 1'b0; feedbackALC = 1'b0; feedbackWR = 1'b0; feedbackRO = 1'b0;
      if (c_cmd > 0) begin
        c_cmd--;
        if (c_cmd == 0) begin
          feedbackCommand = 1'b1;
          if (is_cmd2(pend_byte)) fb_cmd2_cyc = cyc;
        end
      end
      if (c_alc > 0) begin c_alc--; if (c_alc == 0 && !drop_alc) feedbackALC = 1'b1; end
      if (c_wr > 0)  begin c_wr--;  if (c_wr == 0)  feedbackWR = 1'b1; end
      if (c_ro > 0)  begin c_ro--;  if (c_ro == 0)  feedbackRO = 1'b1; end
      if (c_rb > 0)  begin c_rb--;  if (c_rb == 0)  nandRB = 1'b1; end
      if (startCommand) begin
        c_cmd = 3;
        pend_byte = commandByte;
        if (is_cmd2(commandByte) && rb_low > 0) begin nandRB = 1'b0; c_rb = 3 + rb_low; end
      end
      if (startALC) c_alc = 3;
      if (startWR)  c_wr = 3;
      if (startRO)  c_ro = 3;
    end
  end

  task automatic issue(input logic [1:0] code, input logic [31:0] addr);
    @(negedge CLK);
    opValid = 1'b1; opCode = code; opAddress = addr;
    @(negedge CLK);
    opValid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL wait_timeout: %0d events pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drain(input int budget);
    wait_empty(budget);
    @(negedge CLK);
    check("ready_after_op", 32'(opReady), 32'd1);
    check("busy_after_op", 32'(busy), 32'd0);
    check("mux_idle", 32'(MUXselectline), 32'd0);
  endtask

  initial begin : stimulus
    reset = 1'b1; opValid = 1'b0; opCode = 2'b00; opAddress = 32'h0;
    feedbackCommand = 1'b0; feedbackALC = 1'b0; feedbackWR = 1'b0; feedbackRO = 1'b0;
    nandRB = 1'b1; statusByte = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(opReady), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_starts", 32'({startCommand, startALC, startWR, startRO}), 32'd0);
    check("rst_done_err", 32'({opDone, opError}), 32'd0);
    check("rst_cmd_byte", 32'(commandByte), 32'd0);
    check("rst_addr", toAddressLine, 32'd0);
    check("rst_addr_cycles", 32'(addrCycles), 32'd0);
    check("rst_mux", 32'(MUXselectline), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge CLK);

    // READ with nandRB low for 10 cycles.
    rb_low = 10;
    push(EV_CMD, 8'h00, 2'b00, 3'd0, 32'h0);
    push(EV_ALC, 8'h00, 2'b01, 3'd5, 32'h12304567);
    push(EV_CMD, 8'h30, 2'b00, 3'd0, 32'h0);
    push(EV_RO, 8'h00, 2'b11, 3'd0, 32'h0);
    push(EV_DONE, 8'h00, 2'b00, 3'd0, 32'h0);
    issue(2'b00, 32'h12304567);
    drain(200);

    // ERASE with nandRB already high: exit timed by the guard window.
    rb_low = 0;
    push(EV_CMD, 8'h60, 2'b00, 3'd0, 32'h0);
    push(EV_ALC, 8'h00, 2'b01, 3'd3, 32'hAABBCCDD);
    push(EV_CMD, 8'hD0, 2'b00, 3'd0, 32'h0);
    push_pe_tail();
    issue(2'b10, 32'hAABBCCDD);
    drain(200);
`ifdef AUTO_STATUS_EN
    check("rb_guard_latency", 32'(st70_cyc - fb_cmd2_cyc), 32'(RB_GUARD_CYC + 2));
`else
    check("rb_guard_latency", 32'(done_cyc - fb_cmd2_cyc), 32'(RB_GUARD_CYC + 2));
`endif

    // Address engine never answers: error exactly TIMEOUT cycles after ADDR_W entry.
    drop_alc = 1'b1;
    push(EV_CMD, 8'h00, 2'b00, 3'd0, 32'h0);
    push(EV_ALC, 8'h00, 2'b01, 3'd5, 32'h01020304);
    push(EV_ERR, 8'h00, 2'b00, 3'd0, 32'h0);
    issue(2'b00, 32'h01020304);
    drain(TIMEOUT_CYC + 100);
    check("timeout_latency", 32'(err_cyc - alc_cyc), 32'(TIMEOUT_CYC + 1));
    drop_alc = 1'b0;

    // PROGRAM with a second request while busy: the second is ignored.
    rb_low = 5;
    push(EV_CMD, 8'h80, 2'b00, 3'd0, 32'h0);
    push(EV_ALC, 8'h00, 2'b01, 3'd5, 32'hDEADBEEF);
    push(EV_WR, 8'h00, 2'b10, 3'd0, 32'h0);
    push(EV_CMD, 8'h10, 2'b00, 3'd0, 32'h0);
    push_pe_tail();
    issue(2'b01, 32'hDEADBEEF);
    repeat (4) @(negedge CLK);
    opValid = 1'b1; opCode = 2'b10; opAddress = 32'h55555555;
    repeat (3) @(negedge CLK);
    opValid = 1'b0;
    drain(300);

    // PROGRAM interrupted by reset in WDATA_W: back to IDLE, no done/error.
    push(EV_CMD, 8'h80, 2'b00, 3'd0, 32'h0);
    push(EV_ALC, 8'h00, 2'b01, 3'd5, 32'h00000042);
    push(EV_WR, 8'h00, 2'b10, 3'd0, 32'h0);
    issue(2'b01, 32'h00000042);
    wait_empty(200);
    @(negedge CLK);
    check("busy_in_wdata_w", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    check("reset_mid_ready", 32'(opReady), 32'd1);
    check("reset_mid_done_err", 32'({opDone, opError}), 32'd0);
    check("reset_mid_cmd_byte", 32'(commandByte), 32'd0);
    repeat (10) @(negedge CLK);
    check("reset_mid_idle", 32'(busy), 32'd0);

    // STATUS.
    push(EV_CMD, 8'h70, 2'b00, 3'd0, 32'h0);
    push(EV_RO, 8'h00, 2'b11, 3'd0, 32'h0);
    push(EV_DONE, 8'h00, 2'b00, 3'd0, 32'h0);
    issue(2'b11, 32'h0);
    drain(200);

`ifdef AUTO_STATUS_EN
    // PROGRAM with failing then passing status byte.
    statusByte = 8'h01;
    push(EV_CMD, 8'h80, 2'b00, 3'd0, 32'h0);
    push(EV_ALC, 8'h00, 2'b01, 3'd5, 32'h11223344);
    push(EV_WR, 8'h00, 2'b10, 3'd0, 32'h0);
    push(EV_CMD, 8'h10, 2'b00, 3'd0, 32'h0);
    push_pe_tail();
    issue(2'b01, 32'h11223344);
    drain(300);
    statusByte = 8'hE0;
    push(EV_CMD, 8'h80, 2'b00, 3'd0, 32'h0);
    push(EV_ALC, 8'h00, 2'b01, 3'd5, 32'h11223344);
    push(EV_WR, 8'h00, 2'b10, 3'd0, 32'h0);
    push(EV_CMD, 8'h10, 2'b00, 3'd0, 32'h0);
    push_pe_tail();
    issue(2'b01, 32'h11223344);
    drain(300);
`endif

    repeat (5) @(negedge CLK);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
